fetch_queue: RTL and testbench

Instruction-fetch stage sitting directly upstream of the pipelined datapath's decode register: it owns the PC, issues word reads to a variable-latency instruction memory, buffers returned instructions with their PCs in a small in-order queue, and presents Instr_F/PCF/PCPlus4_F to decode with a valid/stall handshake. Taken branches and jumps from execute (PCSrc, PCTargetE) arrive as a redirect that flushes everything fetched down the wrong path.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_ring.sv | 78 +++++++
 rtl/fetch_queue.sv | 90 +++++++++
 tb/tb_fetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_ring.sv
// In-order ring of fetched instructions: entries are allocated at issue, filled on response,
// popped at the head by decode. Flush empties the ring in one cycle.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           alloc_i,
  input  logic [31:0]                    alloc_pc_i,
  input  logic                           fill_i,
  input  logic [31:0]                    fill_instr_i,
  input  logic                           pop_i,
  output fetch_entry_t                   head_o,
  output logic [$clog2(DEPTH+1)-1:0]     live_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t entries_q [DEPTH];
  fetch_entry_t entries_d [DEPTH];
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d;
  logic [CW-1:0] live_q, live_d;

  assign head_o = entries_q[head_ptr_q];
  assign live_o = live_q;

  always_comb begin
    entries_d   = entries_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    live_d      = live_q;
    if (flush_i) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      live_d      = '0;
    end else begin
      if (alloc_i) begin
        entries_d[alloc_ptr_q] = '{pc: alloc_pc_i, instr: NOP_INSTR, filled: 1'b0};
        alloc_ptr_d            = alloc_ptr_q + PW'(1);
      end
      // Fill never targets the entry being allocated: that would require a full ring.
      if (fill_i) begin
        entries_d[fill_ptr_q].instr  = fill_instr_i;
        entries_d[fill_ptr_q].filled = 1'b1;
        fill_ptr_d                   = fill_ptr_q + PW'(1);
      end
      if (pop_i) begin
        head_ptr_d = head_ptr_q + PW'(1);
      end
      live_d = live_q + CW'(alloc_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q   <= '{default: '0};
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      live_q      <= '0;
    end else begin
      entries_q   <= entries_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      live_q      <= live_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues reads to a variable-latency imem, and hands buffered
// instructions to decode. Redirects flush the ring and discard responses still owed.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] live;
  fetch_entry_t  head;
  logic          issue, pop, keep_resp;

  assign imem_req  = !reset && !redirect && (live < CW'(DEPTH)) && (outstanding_q < CW'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign issue     = imem_req && imem_gnt;

  assign valid_f    = (live != '0) && head.filled;
  assign pop        = valid_f && !stall_d && !redirect;
  assign keep_resp  = imem_rvalid && (drop_q == '0) && !redirect;

  assign instr_f    = valid_f ? head.instr : NOP_INSTR;
  assign pc_f       = valid_f ? head.pc : 32'h0;
  assign pc_plus4_f = valid_f ? head.pc + 32'd4 : 32'h0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
    drop_d        = drop_q;
    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (imem_rvalid && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
    // Every read still in flight belongs to the flushed path.
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outstanding_q - CW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (redirect),
    .alloc_i      (issue),
    .alloc_pc_i   (fetch_pc_q),
    .fill_i       (keep_resp),
    .fill_instr_i (imem_rdata),
    .pop_i        (pop),
    .head_o       (head),
    .live_o       (live)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: an in-order imem model with configurable latency feeds the
// DUT; granted fetches are queued as expectations and compared as decode pops them.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } sb_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
    logic        stale;
  } mem_t;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall_d;
  logic [31:0] redirect_pc;
  logic        valid_f;
  logic [31:0] instr_f, pc_f, pc_plus4_f;

  logic        h_req, h_gnt, h_rvalid, h_valid, h_redirect, h_stall;
  logic [31:0] h_addr, h_rdata, h_rpc, h_instr, h_pc, h_p4;

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall_d     (stall_d),
    .valid_f     (valid_f),
    .instr_f     (instr_f),
    .pc_f        (pc_f),
    .pc_plus4_f  (pc_plus4_f)
  );

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF8)
  ) dut_hi (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (h_req),
    .imem_addr   (h_addr),
    .imem_gnt    (h_gnt),
    .imem_rvalid (h_rvalid),
    .imem_rdata  (h_rdata),
    .redirect    (h_redirect),
    .redirect_pc (h_rpc),
    .stall_d     (h_stall),
    .valid_f     (h_valid),
    .instr_f     (h_instr),
    .pc_f        (h_pc),
    .pc_plus4_f  (h_p4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  sb_t  exp_q [$];
  mem_t mem_q [$];
  logic [31:0] h_addrs [$];
  logic [31:0] exp_pc;
  logic [31:0] cyc = 0;
  int          rel = 0;
  int          rst_cyc = 0;
  int          first_valid_rel = -1;
  int          fires = 0;
  int          h_wraps = 0;
  int unsigned lat = 1;
  logic        rst_want, stall_want, gnt_rand;
  logic        h_pend;
  logic [31:0] h_pend_addr;
  logic        obs_req, obs_valid, obs_rv;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic cycle(input logic rd, input logic [31:0] rpc);
    mem_t m;
    sb_t  s;
    logic rv, exp_req, exp_valid, found;
    int   outst;
    @(negedge clk);
    reset       = rst_want;
    stall_d     = stall_want;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    m  = '0;
    rv = 1'b0;
    if (!rst_want && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m  = mem_q.pop_front();
      rv = 1'b1;
    end
    imem_rvalid = rv;
    imem_rdata  = rv ? m.data : 32'h0;
    h_rvalid    = h_pend && !rst_want;
    h_rdata     = inst_of(h_pend_addr);
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = valid_f;
    obs_pc    = pc_f;
    obs_instr = instr_f;
    obs_rv    = rv;
    if (rst_want) begin
      check("req_in_reset", 32'(imem_req), 32'd0);
      if (rst_cyc > 0) begin
        check("rst_valid", 32'(valid_f), 32'd0);
        check("rst_instr", instr_f, NOP);
        check("rst_pc", pc_f, 32'd0);
      end
      rst_cyc++;
      rel = 0;
      first_valid_rel = -1;
      exp_q.delete();
      mem_q.delete();
      exp_pc = RESET_PC;
      h_pend = 1'b0;
      h_addrs.delete();
    end else begin
      rst_cyc   = 0;
      outst     = mem_q.size() + (rv ? 1 : 0);
      exp_req   = !rd && (exp_q.size() < 4) && (outst < 4);
      exp_valid = (exp_q.size() > 0) && exp_q[0].filled;
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) check("imem_addr", imem_addr, exp_pc);
      check("valid_f", 32'(valid_f), 32'(exp_valid));
      if (exp_valid && valid_f) begin
        check("pc_f", pc_f, exp_q[0].pc);
        check("instr_f", instr_f, exp_q[0].instr);
        check("pc_plus4_f", pc_plus4_f, exp_q[0].pc + 32'd4);
      end else if (!valid_f) begin
        check("idle_instr", instr_f, NOP);
        check("idle_pc", pc_f, 32'd0);
        check("idle_p4", pc_plus4_f, 32'd0);
      end
      if (valid_f && first_valid_rel < 0) first_valid_rel = rel;
      if (imem_req && imem_gnt) begin
        fires++;
        mem_q.push_back('{data: inst_of(imem_addr), due: cyc + lat, stale: rd});
      end
      if (rd) begin
        exp_q.delete();
        foreach (mem_q[i]) begin
          m = mem_q[i];
          m.stale = 1'b1;
          mem_q[i] = m;
        end
        exp_pc = {rpc[31:2], 2'b00};
      end else begin
        if (exp_valid && !stall_want) void'(exp_q.pop_front());
        if (rv && !m.stale) begin
          found = 1'b0;
          foreach (exp_q[i]) begin
            if (!found && !exp_q[i].filled) begin
              s = exp_q[i];
              s.filled = 1'b1;
              exp_q[i] = s;
              found = 1'b1;
            end
          end
          if (!found) check("fill_target", 32'd0, 32'd1);
        end
        if (imem_req && imem_gnt) begin
          exp_q.push_back('{pc: exp_pc, instr: inst_of(exp_pc), filled: 1'b0});
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (h_req && h_addrs.size() < 3) h_addrs.push_back(h_addr);
      if (h_valid && h_pc == 32'hFFFF_FFFC) begin
        check("hi_p4_wrap", h_p4, 32'd0);
        h_wraps++;
      end
      h_pend      = h_req;
      h_pend_addr = h_addr;
      rel++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_want = 1'b1;
    repeat (2) cycle(1'b0, 32'h0);
    rst_want = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    h_gnt = 1'b1; h_rvalid = 1'b0; h_rdata = 32'h0; h_redirect = 1'b0; h_stall = 1'b0;
    h_rpc = 32'h0; h_pend = 1'b0; h_pend_addr = 32'h0;
    stall_want = 1'b0; gnt_rand = 1'b0; exp_pc = RESET_PC;

    // Streaming with 1-cycle memory.
    lat = 1;
    do_reset();
    repeat (12) cycle(1'b0, 32'h0);
    check("first_valid_rel", 32'(first_valid_rel), 32'd2);

    // Decode stalled: ring fills to DEPTH and issue stops.
    stall_want = 1'b1;
    do_reset();
    fires = 0;
    repeat (10) cycle(1'b0, 32'h0);
    check("stall_fires", 32'(fires), 32'd4);
    check("stall_req_low", 32'(obs_req), 32'd0);
    check("stall_head_pc", obs_pc, 32'h0);
    stall_want = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 32'h0);
      if (obs_req) break;
    end
    check("resume_req", 32'(obs_req), 32'd1);
    check("resume_addr", obs_addr, 32'h10);
    repeat (10) cycle(1'b0, 32'h0);

    // Redirect with 3 reads in flight.
    lat = 4;
    do_reset();
    repeat (3) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0103);
    cycle(1'b0, 32'h0);
    check("redir_req", 32'(obs_req), 32'd1);
    check("redir_addr", obs_addr, 32'h100);
    for (int i = 0; i < 40; i++) begin
      if (obs_valid) break;
      cycle(1'b0, 32'h0);
    end
    check("redir_valid", 32'(obs_valid), 32'd1);
    check("redir_pc", obs_pc, 32'h100);
    check("redir_instr", obs_instr, inst_of(32'h100));
    repeat (6) cycle(1'b0, 32'h0);

    // Redirect coinciding with a response and a would-be pop.
    lat = 1;
    do_reset();
    repeat (6) cycle(1'b0, 32'h0);
    cycle(1'b1, 32'h0000_0200);
    check("coinc_valid", 32'(obs_valid), 32'd1);
    check("coinc_rvalid", 32'(obs_rv), 32'd1);
    cycle(1'b0, 32'h0);
    check("coinc_next_valid", 32'(obs_valid), 32'd0);
    repeat (10) cycle(1'b0, 32'h0);

    // Random grants, stalls and redirects.
    lat = 2;
    gnt_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      stall_want = ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 24) == 0, $urandom);
    end
    gnt_rand = 1'b0;
    stall_want = 1'b0;

    // Reset while reads are in flight and entries are live.
    lat = 2;
    stall_want = 1'b1;
    do_reset();
    repeat (2) cycle(1'b0, 32'h0);
    do_reset();
    stall_want = 1'b0;
    cycle(1'b0, 32'h0);
    check("restart_req", 32'(obs_req), 32'd1);
    check("restart_addr", obs_addr, RESET_PC);
    repeat (8) cycle(1'b0, 32'h0);

    // High RESET_PC instance: address wrap.
    check("hi_addr_cnt", 32'(h_addrs.size()), 32'd3);
    if (h_addrs.size() == 3) begin
      check("hi_addr0", h_addrs[0], 32'hFFFF_FFF8);
      check("hi_addr1", h_addrs[1], 32'hFFFF_FFFC);
      check("hi_addr2", h_addrs[2], 32'h0000_0000);
    end
    check("hi_wrap_seen", 32'(h_wraps > 0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
